// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the serial sequence detector.
//   state_t    : run-control states (IDLE / RUN / DONE)
//   PAT_W_DEF  : default maximum pattern length in bits
//   CNT_W_DEF  : default match counter / limit width
//   len_ok()   : pattern-length legality check (1..pat_w)
package seq_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic len_ok(input logic [3:0] len, input int pat_w);
    return (len != 4'd0) && (int'(len) <= pat_w);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: history shift register, fill counter and masked pattern compare.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : clear history and fill (run start)
//   clear_fill  : restart fill on this beat (non-overlap match)
//   beat        : accepted serial bit this cycle
//   data        : serial bit
//   pattern,len : active pattern and its length
//   hit         : combinational, the current beat completes the pattern
//   match_hit   : hit, registered one cycle
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             clear_fill,
  input  logic             beat,
  input  logic             data,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
  output logic             hit,
  output logic             match_hit
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] mask;
  logic [PAT_W:0]   mask_w;
  logic [3:0]       fill;
  logic [4:0]       fill_nxt;

  always_comb begin
    hist_nxt = {hist[PAT_W-2:0], data};
    fill_nxt = {1'b0, fill} + 5'd1;
    // One extra bit so that len == PAT_W still yields an all-ones mask.
    mask_w   = ((PAT_W+1)'(1) << len) - (PAT_W+1)'(1);
    mask     = mask_w[PAT_W-1:0];
    // The current beat is compared together with the history, so the
    // result lands in match_hit one edge after the completing beat.
    hit      = beat && (fill_nxt >= {1'b0, len}) &&
               (((hist_nxt ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      match_hit <= 1'b0;
    end else begin
      match_hit <= hit;
      if (clear) begin
        hist <= '0;
        fill <= '0;
      end else if (beat) begin
        hist <= hist_nxt;
        if (clear_fill)
          fill <= '0;
        else if (fill < len)
          fill <= fill_nxt[3:0];
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-controlled programmable serial sequence detector.
//   clk, rst            : clock, synchronous active-high reset
//   cfg_we, cfg_*       : configuration, latched only in IDLE
//   start, abort        : run control
//   in_valid, in        : serial bit stream, consumed while in_ready
//   in_ready, busy      : RUN / RUN-or-DONE indicators
//   match, match_count  : per-occurrence pulse and running count
//   done, err           : run-complete pulse, sticky illegal-config flag
//
// state | meaning
// IDLE  | waiting for config writes and start
// RUN   | consuming serial bits, counting matches
// DONE  | limit reached; one-cycle done pulse, then IDLE
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             in_ready,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [3:0]       len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] lim_q;

  logic             cfg_legal;
  logic             beat;
  logic             run_clear;
  logic             hit;
  logic [CNT_W-1:0] count_inc;

  assign cfg_legal = len_ok(len_q, PAT_W) && (lim_q != '0);
  // An abort discards any beat presented in the same cycle.
  assign beat      = (state == RUN) && in_valid && !abort;
  assign run_clear = (state == IDLE) && start && cfg_legal;
  assign count_inc = match_count + CNT_W'(1);

  assign in_ready  = (state == RUN);
  assign busy      = (state != IDLE);

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .clear      (run_clear),
    .clear_fill (hit && !ovl_q),
    .beat       (beat),
    .data       (in),
    .pattern    (pat_q),
    .len        (len_q),
    .hit        (hit),
    .match_hit  (match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      lim_q       <= '0;
      match_count <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            lim_q <= cfg_limit;
          end
          if (start) begin
            if (cfg_legal) begin
              match_count <= '0;
              err         <= 1'b0;
              state       <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (hit) begin
            match_count <= count_inc;
            // Leave RUN on the completing edge so done lines up with match.
            if (count_inc == lim_q) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_limit;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       din;
  logic       in_ready;
  logic       busy;
  logic       match;
  logic [7:0] match_count;
  logic       done;
  logic       err;

  seq_det_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_limit   (cfg_limit),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in          (din),
    .in_ready    (in_ready),
    .busy        (busy),
    .match       (match),
    .match_count (match_count),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cnt;
    bit dn;
    int cyc;
  } exp_t;
  exp_t sb[$];

  // reference model state
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  int       m_lim;
  bit       m_run;
  int       m_cnt;
  bit       m_err;
  bit       m_seg[$];

  // pending config values for the next cfg write
  bit [7:0] p_pat;
  int       p_len;
  bit       p_ovl;
  int       p_lim;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bits consumed since the last start (or last non-overlap match);
  // a match is simply "the newest m_len bits spell the pattern".
  task automatic model_beat(input bit b);
    bit ok;
    m_seg.push_back(b);
    if (m_seg.size() > 16) void'(m_seg.pop_front());
    if (m_seg.size() >= m_len) begin
      ok = 1'b1;
      for (int i = 0; i < m_len; i++)
        if (m_seg[m_seg.size() - m_len + i] != m_pat[m_len - 1 - i]) ok = 1'b0;
      if (ok) begin
        m_cnt++;
        sb.push_back('{cnt: m_cnt, dn: (m_cnt == m_lim), cyc: cyc + 1});
        if (!m_ovl) m_seg.delete();
        if (m_cnt == m_lim) m_run = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit we, input bit st, input bit ab, input bit v, input bit b);
    @(negedge clk);
    cfg_we   = we;
    start    = st;
    abort    = ab;
    in_valid = v;
    din      = b;
    if (we) begin
      cfg_pattern = p_pat;
      cfg_len     = 4'(p_len);
      cfg_overlap = p_ovl;
      cfg_limit   = 8'(p_lim);
    end
    if (st && !m_run) begin
      if (m_len >= 1 && m_len <= 8 && m_lim >= 1) begin
        m_run = 1'b1;
        m_cnt = 0;
        m_err = 1'b0;
        m_seg.delete();
      end else begin
        m_err = 1'b1;
      end
    end else if (m_run && ab) begin
      m_run = 1'b0;
    end else if (m_run && v) begin
      model_beat(b);
    end
    if (we && !m_run) begin
      m_pat = p_pat;
      m_len = p_len;
      m_ovl = p_ovl;
      m_lim = p_lim;
    end
  endtask

  task automatic cfg(input bit [7:0] p, input int l, input bit o, input int lim);
    p_pat = p;
    p_len = l;
    p_ovl = o;
    p_lim = lim;
    drive(1, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic beats(input bit [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(0, 0, 0, 1, bits[i]);
  endtask

  // monitor: pops the scoreboard whenever the DUT reports a match
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_match: got none expected count %0d at cycle %0d", sb[0].cnt, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (match) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_match: got match=1 count %0d expected none (cycle %0d)", match_count, cyc);
        end else begin
          e = sb.pop_front();
          chk("match_cycle", cyc, e.cyc);
          chk("match_count", int'(match_count), e.cnt);
          chk("done_with_match", int'(done), int'(e.dn));
        end
      end else if (done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_without_match: got done=1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    bit r;
    bit v;
    bit b;
    rst = 1'b1;
    cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_limit = 0;
    start = 0; abort = 0; in_valid = 0; din = 0;
    m_pat = 0; m_len = 0; m_ovl = 0; m_lim = 0; m_run = 0; m_cnt = 0; m_err = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_match", match, 0);
    chk("rst_count", match_count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // non-overlap: one match
    cfg(8'b1101, 4, 0, 5);
    drive(0, 1, 0, 0, 0);
    beats(16'b1101101, 7);
    idle(2);
    chk("nonovl_count", match_count, 1);
    chk("nonovl_busy", busy, 1);
    drive(0, 0, 1, 0, 0);
    idle(1);
    chk("nonovl_abort_busy", busy, 0);

    // overlap: two matches
    cfg(8'b1101, 4, 1, 5);
    drive(0, 1, 0, 0, 0);
    beats(16'b1101101, 7);
    idle(2);
    chk("ovl_count", match_count, 2);
    drive(0, 0, 1, 0, 0);
    idle(1);

    // abort with a completing beat in the same cycle
    cfg(8'b1101, 4, 0, 5);
    drive(0, 1, 0, 0, 0);
    beats(16'b1101110, 7);
    drive(0, 0, 1, 1, 1);
    idle(1);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_count", match_count, 1);
    idle(1);

    // limit reached on the second overlapping match
    cfg(8'b11, 2, 1, 2);
    drive(0, 1, 0, 0, 0);
    beats(16'b111, 3);
    drive(0, 0, 0, 1, 1);
    chk("limit_done", done, 1);
    chk("limit_in_ready", in_ready, 0);
    chk("limit_busy", busy, 1);
    idle(1);
    chk("limit_idle_busy", busy, 0);
    chk("limit_done_clear", done, 0);
    chk("limit_count", match_count, 2);

    // illegal configs
    cfg(8'h00, 0, 0, 3);
    drive(0, 1, 0, 0, 0);
    idle(1);
    chk("illegal_len0_err", err, 1);
    chk("illegal_len0_busy", busy, 0);
    cfg(8'h01, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    idle(1);
    chk("illegal_lim0_err", err, 1);
    cfg(8'hff, 9, 0, 1);
    drive(0, 1, 0, 0, 0);
    idle(1);
    chk("illegal_len9_err", err, 1);
    chk("illegal_len9_busy", busy, 0);
    cfg(8'h01, 1, 1, 1);
    drive(0, 1, 0, 0, 0);
    idle(1);
    chk("legal_clears_err", err, 0);
    chk("legal_in_ready", in_ready, 1);
    beats(16'b1, 1);
    idle(2);

    // in_valid gaps inside a pattern
    cfg(8'b1101, 4, 0, 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    idle(2);
    chk("gap_count", match_count, 1);

    // cfg_we during a run is ignored; 2'b11 would match on beat 2 if taken
    cfg(8'b1101, 4, 1, 1);
    drive(0, 1, 0, 0, 0);
    p_pat = 8'b11; p_len = 2; p_ovl = 1; p_lim = 1;
    drive(1, 0, 0, 0, 0);
    beats(16'b1101, 4);
    idle(2);
    chk("cfg_locked_count", match_count, 1);

    // reset mid-run
    cfg(8'b1101, 4, 1, 3);
    drive(0, 1, 0, 0, 0);
    beats(16'b11011, 5);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    m_run = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_lim = 0; m_cnt = 0; m_err = 0;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_match", match, 0);
    chk("midrst_count", match_count, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    rst = 1'b0;

    // randomized runs against the model
    for (int run = 0; run < 40; run++) begin
      int l;
      bit [7:0] p;
      bit fed;
      l = $urandom_range(1, 8);
      p = 8'($urandom_range(0, 255)) & 8'((1 << l) - 1);
      fed = $urandom_range(0, 1) != 0;
      cfg(p, l, $urandom_range(0, 1) != 0, $urandom_range(1, 4));
      drive(0, 1, 0, 0, 0);
      for (int k = 0; k < 60 && m_run; k++) begin
        v = $urandom_range(0, 3) != 0;
        b = fed ? p[(l - 1) - (k % l)] : bit'($urandom_range(0, 1));
        r = m_run;
        drive(0, 0, ($urandom_range(0, 59) == 0), v, b);
        chk("rand_in_ready", in_ready, r);
      end
      if (m_run) drive(0, 0, 1, 0, 0);
      idle(2);
      chk("rand_err", err, m_err);
      chk("rand_count", match_count, m_cnt);
    end

    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
